// File: rtl/systolic_pkg.sv
// Shared types and helpers for the parametrised systolic MAC array.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ACC_W  = 32;

  // Cycles from the edge that accepts the last beat until the far corner PE has accumulated it.
  function automatic int drain_cycles(input int size);
    return 2 * size - 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards A east and B south through one register each
// and accumulates the signed product with a synchronous clear.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] a_d, a_q, b_d, b_q;
  logic signed [ACC_W-1:0]  acc_d, acc_q;

  always_comb begin
    prod  = PW'(a_in) * PW'(b_in);
    a_d   = clr ? '0 : a_in;
    b_d   = clr ? '0 : b_in;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      // Two's-complement wrap is intentional; no saturation.
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign acc   = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// Output-stationary SIZE x SIZE signed MAC array with internal operand skew.
// Define SYSTOLIC_MAC_RELU_EN to clamp negative entries of `result` to zero.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int K_MAX  = 256,
  parameter int KW     = $clog2(K_MAX + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [KW-1:0]                        k_len,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SIZE-1:0][DATA_W-1:0]          in_west,
  input  logic [SIZE-1:0][DATA_W-1:0]          in_north,
  output logic                                 busy,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] result,
  output logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0] result_raw
);

  localparam int DRAIN_N = drain_cycles(SIZE);
  localparam int DW      = $clog2(DRAIN_N + 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     beat_q, beat_d;
  logic [KW-1:0]     klen_q, klen_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              clr, acc_en, accept;

  logic [2*DATA_W-1:0]      inj     [SIZE];
  logic [2*DATA_W-1:0]      lane_sk [SIZE];
  logic signed [DATA_W-1:0] a_h     [SIZE][SIZE+1];
  logic signed [DATA_W-1:0] b_v     [SIZE+1][SIZE];
  logic signed [ACC_W-1:0]  acc     [SIZE][SIZE];

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    klen_d  = klen_q;
    drain_d = drain_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr    = 1'b1;
          beat_d = '0;
          if (k_len == '0) begin
            state_d = ST_DONE;
          end else begin
            klen_d  = k_len;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        acc_en = 1'b1;
        if (accept) begin
          beat_d = beat_q + KW'(1);
          if (beat_q + KW'(1) == klen_q) begin
            state_d = ST_DRAIN;
            drain_d = DW'(DRAIN_N - 1);
          end
        end
      end
      ST_DRAIN: begin
        acc_en = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      klen_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      klen_q  <= klen_d;
      drain_q <= drain_d;
    end
  end

  // Bubbles and non-LOAD cycles inject zeros so every lane stays aligned.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      inj[i] = accept ? {in_west[i], in_north[i]} : '0;
    end
  end

  // West lane i and north lane i share the same delay of i cycles.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign lane_sk[gi] = inj[gi];
    end else begin : g_delay
      logic [2*DATA_W-1:0] sr_d [gi];
      logic [2*DATA_W-1:0] sr_q [gi];

      always_comb begin
        sr_d[0] = clr ? '0 : inj[gi];
        for (int k = 1; k < gi; k++) begin
          sr_d[k] = clr ? '0 : sr_q[k-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < gi; k++) sr_q[k] <= '0;
        end else begin
          sr_q <= sr_d;
        end
      end

      assign lane_sk[gi] = sr_q[gi-1];
    end

    assign a_h[gi][0] = lane_sk[gi][2*DATA_W-1 -: DATA_W];
    assign b_v[0][gi] = lane_sk[gi][DATA_W-1:0];
  end

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (acc_en),
        .a_in  (a_h[gi][gj]),
        .b_in  (b_v[gi][gj]),
        .a_out (a_h[gi][gj+1]),
        .b_out (b_v[gi+1][gj]),
        .acc   (acc[gi][gj])
      );

      assign result_raw[gi][gj] = acc[gi][gj];
`ifdef SYSTOLIC_MAC_RELU_EN
      assign result[gi][gj] = acc[gi][gj][ACC_W-1] ? '0 : acc[gi][gj];
`else
      assign result[gi][gj] = acc[gi][gj];
`endif
    end
  end

  // Operands leaving the east and south edges carry no further information.
  logic unused_edges;
  always_comb begin
    unused_edges = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      unused_edges = unused_edges ^ (^a_h[i][SIZE]) ^ (^b_v[SIZE][i]);
    end
  end

endmodule

// File: doc/systolic_mac_array.md
Name: systolic_mac_array

Overview:
- Parametrised output-stationary SIZE x SIZE signed MAC array, the successor of the fixed 4x4 systolic_array.
- Takes one A-column and one B-row per beat over a valid/ready stream of programmable length k_len.
- Skews operands internally, so the host feeds unskewed vectors.
- After the wavefront drains, it presents the SIZE x SIZE result matrix under an out_valid/out_ready handshake to the NPU datapath.

Parameters:
- SIZE, 4, array rows = columns
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator/result width (must be >= 2*DATA_W)
- K_MAX, 256, maximum beats per job; KW = $clog2(K_MAX+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  job start pulse, sampled only in IDLE
- k_len  in  KW  beats in this job, latched on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat
- in_west  in  SIZE x DATA_W signed  A column, lane i feeds row i
- in_north  in  SIZE x DATA_W signed  B row, lane j feeds column j
- busy  out  1  high in LOAD/DRAIN/DONE
- out_valid  out  1  result matrix valid
- out_ready  in  1  consumer accepts result
- result  out  SIZE x SIZE x ACC_W  result (post-ReLU if enabled)
- result_raw  out  SIZE x SIZE x ACC_W  signed accumulator values

Behaviour:
- Reset (async, rst=1): state IDLE; all accumulators, skew and forwarding registers 0; in_ready=0, busy=0, out_valid=0; result = result_raw = 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - start=1 and k_len>0: clear all accumulators and skew registers, latch k_len, go to LOAD.
  - start=1 and k_len=0: clear accumulators, go directly to DONE; results are all zero.
- LOAD:
  - in_ready=1.
  - Beat accepted when in_valid & in_ready; beat counter increments.
  - Cycle with in_valid=0 is a bubble: zeros are injected on all lanes, no counter change, alignment preserved.
  - When the k_len-th beat is accepted, go to DRAIN the next cycle.
  - in_ready=0 in every other state.
- Skew: lane i of in_west is delayed i cycles, lane j of in_north j cycles. PE(i,j) forwards A east and B south through one register each.
- DRAIN: fixed-length countdown. With the last beat accepted in cycle L, out_valid rises in cycle L + 2*SIZE (L+8 for SIZE=4). Transition to DONE then.
- DONE:
  - result/result_raw are held stable and out_valid=1 until out_ready=1.
  - On that handshake cycle, go to IDLE; out_valid=0 next cycle.
  - Result registers keep their last value in IDLE.
- start outside IDLE is ignored. in_valid outside LOAD is ignored.
- Arithmetic:
  - Product is DATA_W x DATA_W signed, sign-extended to ACC_W.
  - Accumulation is two's-complement modulo 2^ACC_W; no saturation.
- rst asserted mid-job aborts immediately to the reset state; no partial result is ever flagged valid.
- busy = (state != IDLE).

Optional Feature:
- Macro SYSTOLIC_MAC_RELU_EN.
- Defined: result[i][j] = 0 when result_raw[i][j] is negative, else result_raw[i][j].
- Undefined: result is wired identically to result_raw.
- result_raw behaviour is unchanged in both builds.

Decomposition:
- Package systolic_pkg holds:
  - state enum (IDLE, LOAD, DRAIN, DONE)
  - default widths DATA_W/ACC_W
  - drain-length function drain_cycles(SIZE) = 2*SIZE-1
- Sub-module systolic_pe, one per grid position, parametrised by DATA_W/ACC_W:
  - registered A/B forwarding
  - accumulator with synchronous clear and async rst
- Top level holds the FSM, skew shift registers, beat/drain counters and the optional ReLU.

Test Plan:
- Single beat: SIZE=4, k_len=1, in_west=[2,-1,3,0], in_north=[1,2,0,0].
  - result_raw rows = [2,4,0,0], [-1,-2,0,0], [3,6,0,0], [0,0,0,0].
  - With SYSTOLIC_MAC_RELU_EN, row1 of result = 0.
  - out_valid in cycle L+8.
- Identity GEMM: k_len=4, beat k: in_west = column k of I4, in_north = row k of B = [[1,2,3,4],[5,6,7,8],[9,10,11,12],[13,14,15,16]].
  - result_raw == B.
  - Repeat with random in_valid bubbles: identical result, out_valid delayed only by the bubble count.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid.
  - result stable, in_ready=0, start pulses ignored.
  - out_ready=1 returns to IDLE next cycle.
- Overflow wrap: ACC_W=16, k_len=3, all lanes 127 each beat.
  - result_raw[0][0] = 48387 mod 2^16 = -17149.
- k_len=0 start: DONE with all-zero results, out_valid the cycle after start.
- Reset mid-DRAIN: assert rst.
  - out_valid, in_ready, busy drop to 0 immediately; accumulators 0.
  - A fresh single-beat job then yields the correct result.
